// File: rtl/FIFO_pkg.sv
// Shared FIFO constants and the operation enum used by the responder and its bench.
package FIFO_pkg;

  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE_OP,
    WRITE_OP,
    READ_OP,
    WRITE_READ_OP
  } STATE_e;

  function automatic STATE_e op_kind(input logic wr, input logic rd);
    return STATE_e'({rd, wr});
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Dual-port storage for the FIFO: synchronous write port, registered read port.
module fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  // Storage array is never reset so it maps onto block RAM.
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/sync_fifo_responder.sv
// Synchronous FIFO with per-access status and occupancy flags.
// Define FIFO_STICKY_ERR_EN to make overflow/underflow hold until reset.
module sync_fifo_responder
  import FIFO_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_pkg::FIFO_WIDTH,
  parameter int FIFO_DEPTH = FIFO_pkg::FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  empty,
  output logic                  almostempty,
  output logic                  half_full,
  output logic                  almostfull,
  output logic                  full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          wr_ack_reg;
  logic          overflow_reg;
  logic          underflow_reg;
  logic          wr_ok;
  logic          rd_ok;

  // A request coincident with reset is dropped, including its memory write.
  assign wr_ok = wr_en & ~full & ~rst;
  assign rd_ok = rd_en & ~empty & ~rst;

  fifo_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr_reg),
    .wr_data (data_in),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr_reg),
    .rd_data (data_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      wr_ack_reg    <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      wr_ack_reg <= wr_ok;
`ifdef FIFO_STICKY_ERR_EN
      overflow_reg  <= overflow_reg  | (wr_en & full);
      underflow_reg <= underflow_reg | (rd_en & empty);
`else
      overflow_reg  <= wr_en & full;
      underflow_reg <= rd_en & empty;
`endif
    end
  end

  assign wr_ack      = wr_ack_reg;
  assign overflow    = overflow_reg;
  assign underflow   = underflow_reg;

  // Flags decode the registered count, so they track the post-edge state.
  assign empty       = (count_reg == '0);
  assign almostempty = (count_reg == CW'(1));
  assign half_full   = (count_reg >= CW'(FIFO_DEPTH / 2));
  assign almostfull  = (count_reg == CW'(FIFO_DEPTH - 1));
  assign full        = (count_reg == CW'(FIFO_DEPTH));

endmodule
